pixel_stream_feeder: RTL

Upstream stage of `facial_detection_ip` on the OS clock domain. Buffers incoming 12-bit image pixels in a small FIFO and releases one pixel per `pixel_request` strobe from the detection IP. Each released pixel is tagged with its row/column position and with start-of-frame and end-of-frame markers. The block enforces frame boundaries and flags requests it cannot serve.

---
 rtl/face_detection_pkg.sv | 27 ++
 rtl/pixel_sync_fifo.sv | 63 ++++++
 rtl/pixel_stream_feeder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/face_detection_pkg.sv
// ============================================================================
// Module      : face_detection_pkg
// Description : Shared widths, default frame geometry and feeder FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package face_detection_pkg;

    localparam int DATA_WIDTH_12        = 12;
    localparam int FRAME_WIDTH_DEFAULT  = 640;
    localparam int FRAME_HEIGHT_DEFAULT = 480;
    localparam int FIFO_DEPTH_DEFAULT   = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

    // A one-row frame still needs a 1-bit row field to stay a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_sync_fifo.sv
// ============================================================================
// Module      : pixel_sync_fifo
// Description : Single-clock FIFO with registered read data, updated on pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_sync_fifo #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16
) (
    input  logic                  clk_os,
    input  logic                  reset_os,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]         r_wptr;
    logic [c_AW:0]         r_rptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_do_push;
    logic                  w_do_pop;

    // Extra pointer MSB tells a wrapped (full) FIFO from an empty one.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_data;

    always_ff @(posedge clk_os) begin
        if (w_do_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_data <= r_mem[r_rptr[c_AW-1:0]];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_stream_feeder.sv
// ============================================================================
// Module      : pixel_stream_feeder
// Description : Buffers pixels and releases one per request, tagged with
//               row/col and SOF/EOF. PIXEL_FEEDER_UNDERRUN_CNT_EN adds a
//               saturating underrun counter output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_stream_feeder #(
    parameter int DATA_WIDTH_12 = face_detection_pkg::DATA_WIDTH_12,
    parameter int FRAME_WIDTH   = face_detection_pkg::FRAME_WIDTH_DEFAULT,
    parameter int FRAME_HEIGHT  = face_detection_pkg::FRAME_HEIGHT_DEFAULT,
    parameter int FIFO_DEPTH    = face_detection_pkg::FIFO_DEPTH_DEFAULT
) (
    input  logic                                                   clk_os,
    input  logic                                                   reset_os,
    input  logic                                                   i_pixel_valid,
    input  logic [DATA_WIDTH_12-1:0]                               i_pixel,
    output logic                                                   o_pixel_ready,
    input  logic                                                   i_frame_start,
    input  logic                                                   i_pixel_request,
    output logic [DATA_WIDTH_12-1:0]                               o_pixel,
    output logic                                                   o_pixel_valid,
    output logic [face_detection_pkg::cnt_width(FRAME_WIDTH)-1:0]  o_col,
    output logic [face_detection_pkg::cnt_width(FRAME_HEIGHT)-1:0] o_row,
    output logic                                                   o_sof,
    output logic                                                   o_eof,
    output logic                                                   o_underrun,
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
    output logic [15:0]                                            o_underrun_count,
`endif
    output logic                                                   o_busy
);

    import face_detection_pkg::*;

    localparam int c_COL_W = cnt_width(FRAME_WIDTH);
    localparam int c_ROW_W = cnt_width(FRAME_HEIGHT);
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(FRAME_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(FRAME_HEIGHT - 1);

    feeder_state_t r_state;
    feeder_state_t w_next_state;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_underrun;
    logic               w_start;
    logic               w_last;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] r_out_col;
    logic [c_ROW_W-1:0] r_out_row;
    logic               r_valid;
    logic               r_sof;
    logic               r_eof;
    logic               r_underrun;

    assign w_push     = i_pixel_valid && !w_full;
    assign w_start    = (r_state == IDLE) && i_frame_start;
    assign w_pop      = (r_state == STREAM) && i_pixel_request && !w_empty;
    assign w_underrun = (r_state == STREAM) && i_pixel_request && w_empty;
    assign w_last     = (r_col == c_LAST_COL) && (r_row == c_LAST_ROW);

    pixel_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH_12),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_os   (clk_os),
        .reset_os (reset_os),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_data   (i_pixel),
        .o_data   (o_pixel),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_frame_start)  w_next_state = STREAM;
            STREAM:  if (w_pop && w_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Position counters name the pixel that the next pop will release.
    always_ff @(posedge clk_os) begin
        if (reset_os || w_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_pop) begin
            if (r_col == c_LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_os) begin
        if (reset_os) begin
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_underrun <= 1'b0;
            r_out_col  <= '0;
            r_out_row  <= '0;
        end else begin
            r_valid    <= w_pop;
            r_sof      <= w_pop && (r_col == '0) && (r_row == '0);
            r_eof      <= w_pop && w_last;
            r_underrun <= w_underrun;
            if (w_pop) begin
                r_out_col <= r_col;
                r_out_row <= r_row;
            end
        end
    end

`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk_os) begin
        if (reset_os || w_start) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign o_underrun_count = r_underrun_cnt;
`endif

    assign o_pixel_ready = !w_full;
    assign o_pixel_valid = r_valid;
    assign o_col         = r_out_col;
    assign o_row         = r_out_row;
    assign o_sof         = r_sof;
    assign o_eof         = r_eof;
    assign o_underrun    = r_underrun;
    assign o_busy        = (r_state == STREAM);

endmodule

`default_nettype wire
